// File: rtl/tia_hdecode_if.sv
// tia_hdecode bus: LFSR/HMOVE inputs and horizontal line outputs.
// hcount is present only when TIA_HDECODE_COUNT_EN is defined.
interface tia_hdecode_if;
  logic [5:0] lfsr_in;
  logic       hmove;
  logic       hsync;
  logic       hblank;
  logic       cb;
  logic       center;
  logic       lfsr_reset;
  logic       late_hb;
`ifdef TIA_HDECODE_COUNT_EN
  logic [5:0] hcount;
`endif

`ifdef TIA_HDECODE_COUNT_EN
  modport master (
    output lfsr_in, hmove,
    input  hsync, hblank, cb, center,
    input  lfsr_reset, late_hb, hcount
  );
  modport slave (
    input  lfsr_in, hmove,
    output hsync, hblank, cb, center,
    output lfsr_reset, late_hb, hcount
  );
`else
  modport master (
    output lfsr_in, hmove,
    input  hsync, hblank, cb, center,
    input  lfsr_reset, late_hb
  );
  modport slave (
    input  lfsr_in, hmove,
    output hsync, hblank, cb, center,
    output lfsr_reset, late_hb
  );
`endif
endinterface

// File: rtl/tia_hdecode.sv
// Horizontal timing decoder: s1 decode of the LFSR, s2 set/reset latches.
// Optional TIA_HDECODE_COUNT_EN adds a binary hcount debug output.
module tia_hdecode #(
  parameter logic [5:0] SHB  = 6'h00,
  parameter logic [5:0] SHS  = 6'h3C,
  parameter logic [5:0] RHS  = 6'h37,
  parameter logic [5:0] RCB  = 6'h0F,
  parameter logic [5:0] RHB  = 6'h1C,
  parameter logic [5:0] LRHB = 6'h17,
  parameter logic [5:0] CNT  = 6'h2C,
  parameter logic [5:0] RES  = 6'h14
) (
  input  logic          reset,
  input  logic          s1,
  input  logic          s2,
  tia_hdecode_if.slave  bus
);

  localparam int M_SHB  = 0;
  localparam int M_SHS  = 1;
  localparam int M_RHS  = 2;
  localparam int M_RCB  = 3;
  localparam int M_RHB  = 4;
  localparam int M_LRHB = 5;
  localparam int M_CNT  = 6;
  localparam int M_RES  = 7;

  logic [7:0] match;
  logic       hmove_s;
  logic       hsync_q;
  logic       hblank_q;
  logic       cb_q;
  logic       center_q;
  logic       wrap_q;
  logic       late_q;
  logic       hb_clr;

  // blank release point moves from RHB to LRHB after an HMOVE
  always_comb begin
    hb_clr = late_q ? match[M_LRHB] : match[M_RHB];
  end

  // s1: register the one-hot pattern compare and the HMOVE level
  always_ff @(posedge s1 or posedge reset) begin
    if (reset) begin
      match   <= '0;
      hmove_s <= 1'b0;
    end else begin
      match   <= {bus.lfsr_in == RES,
                  bus.lfsr_in == CNT,
                  bus.lfsr_in == LRHB,
                  bus.lfsr_in == RHB,
                  bus.lfsr_in == RCB,
                  bus.lfsr_in == RHS,
                  bus.lfsr_in == SHS,
                  bus.lfsr_in == SHB};
      hmove_s <= bus.hmove;
    end
  end

  // s2: set/reset latches, set wins on coincidence
  always_ff @(posedge s2 or posedge reset) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      hblank_q <= 1'b1;
      cb_q     <= 1'b0;
      center_q <= 1'b0;
      wrap_q   <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      hblank_q <= match[M_SHB] | (hblank_q & ~hb_clr);
      hsync_q  <= match[M_SHS] | (hsync_q & ~match[M_RHS]);
      cb_q     <= match[M_RHS] | (cb_q & ~match[M_RCB]);
      center_q <= match[M_CNT];
      wrap_q   <= match[M_RES];
      late_q   <= hmove_s | (late_q & ~match[M_RES]);
    end
  end

  assign bus.hsync      = hsync_q;
  assign bus.hblank     = hblank_q;
  assign bus.cb         = cb_q;
  assign bus.center     = center_q;
  assign bus.lfsr_reset = wrap_q;
  assign bus.late_hb    = late_q;

`ifdef TIA_HDECODE_COUNT_EN
  logic [5:0] hcount_q;

  // s2: line position counter, zeroed at line start, saturating
  always_ff @(posedge s2 or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
    end else if (match[M_SHB]) begin
      hcount_q <= '0;
    end else if (hcount_q != 6'd63) begin
      hcount_q <= hcount_q + 6'd1;
    end
  end

  assign bus.hcount = hcount_q;
`endif

endmodule

// File: tb/tb_tia_hdecode.sv
// Scoreboard bench for tia_hdecode against a line-position model.
// Works with or without TIA_HDECODE_COUNT_EN.
module tb_tia_hdecode;

  typedef struct packed {
    logic       hs;
    logic       hb;
    logic       cb;
    logic       ctr;
    logic       rst;
    logic       late;
    logic [5:0] hc;
  } exp_t;

  logic reset;
  logic s1;
  logic s2;
  int   n_chk;
  int   n_fail;
  int   n_step;

  tia_hdecode_if hif ();

  tia_hdecode dut (
    .reset (reset),
    .s1    (s1),
    .s2    (s2),
    .bus   (hif.slave)
  );

  exp_t       sb[$];
  logic [5:0] seq [57];
  logic       m_hs, m_hb, m_cb, m_ctr, m_rst, m_late;
  int         m_hc;

  // two-phase non-overlapping clocks, 20 time units per cycle
  initial begin
    s1 = 0;
    s2 = 0;
    forever begin
      #2 s1 = 1;
      #5 s1 = 0;
      #5 s2 = 1;
      #5 s2 = 0;
      #3;
    end
  end

  function automatic logic [5:0] lnext(logic [5:0] v);
    return {v[1] ^ ~v[0], v[5:1]};
  endfunction

  function automatic int idx_of(logic [5:0] v);
    for (int i = 0; i < 57; i++)
      if (seq[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_hs = 0; m_hb = 1; m_cb = 0;
    m_ctr = 0; m_rst = 0; m_late = 0;
    m_hc = 0;
  endtask

  // effect of one line position (or unknown pattern) on the outputs
  task automatic model_push(logic [5:0] v, logic hm);
    int   k;
    logic clr;
    exp_t e;
    k = idx_of(v);
    clr = m_late ? (k == 18) : (k == 16);
    if (k == 0) m_hb = 1; else if (clr) m_hb = 0;
    if (k == 4) m_hs = 1; else if (k == 8) m_hs = 0;
    if (k == 8) m_cb = 1; else if (k == 12) m_cb = 0;
    m_ctr = (k == 36);
    m_rst = (k == 56);
    m_late = hm | (m_late & (k != 56));
    if (k == 0) m_hc = 0;
    else if (m_hc < 63) m_hc = m_hc + 1;
    e.hs = m_hs; e.hb = m_hb; e.cb = m_cb;
    e.ctr = m_ctr; e.rst = m_rst; e.late = m_late;
    e.hc = 6'(m_hc);
    sb.push_back(e);
  endtask

  // called at negedge s2; returns at the next negedge s2
  task automatic step(logic [5:0] v, logic hm);
    hif.lfsr_in = v;
    hif.hmove = hm;
    model_push(v, hm);
    @(negedge s2);
  endtask

  task automatic line(int hm_at);
    for (int i = 0; i < 57; i++)
      step(seq[i], i == hm_at);
  endtask

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // monitor: compare each s2 update against the scoreboard head
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge s2);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        ok = (hif.hsync == e.hs) && (hif.hblank == e.hb) &&
             (hif.cb == e.cb) && (hif.center == e.ctr) &&
             (hif.lfsr_reset == e.rst) && (hif.late_hb == e.late);
`ifdef TIA_HDECODE_COUNT_EN
        ok = ok && (hif.hcount == e.hc);
`endif
        n_chk++;
        n_step++;
        if (!ok) begin
          n_fail++;
          $display("FAIL sb step %0d: got hs%b hb%b cb%b ct%b rs%b lt%b required hs%b hb%b cb%b ct%b rs%b lt%b hc%0d",
                   n_step, hif.hsync, hif.hblank, hif.cb,
                   hif.center, hif.lfsr_reset, hif.late_hb,
                   e.hs, e.hb, e.cb, e.ctr, e.rst, e.late, e.hc);
        end
`ifdef TIA_HDECODE_COUNT_EN
        if (hif.hcount != e.hc)
          $display("FAIL hcount step %0d: got %0d required %0d",
                   n_step, hif.hcount, e.hc);
`endif
      end
    end
  end

  initial begin
    logic [5:0] cur;
    int         pulses;
    int         gap;
    int         n;
    logic [5:0] rv;
    n_chk = 0;
    n_fail = 0;
    n_step = 0;
    seq[0] = 6'h00;
    for (int i = 1; i < 57; i++) seq[i] = lnext(seq[i-1]);
    model_reset();
    hif.lfsr_in = 6'h00;
    hif.hmove = 0;
    reset = 1;

    #5;
    chk("rst_hblank", hif.hblank, 1);
    chk("rst_hsync", hif.hsync, 0);
    chk("rst_cb", hif.cb, 0);
    chk("rst_center", hif.center, 0);
    chk("rst_lfsr_reset", hif.lfsr_reset, 0);
    chk("rst_late_hb", hif.late_hb, 0);
`ifdef TIA_HDECODE_COUNT_EN
    chk("rst_hcount", int'(hif.hcount), 0);
`endif
    @(negedge s2);
    @(negedge s2);
    reset = 0;

    line(-1);
    line(2);
    line(30);
    line(-1);

    cur = 6'h00;
    pulses = 0;
    gap = 0;
    for (n = 0; n < 300 && pulses < 4; n++) begin
      step(cur, 0);
      gap++;
      if (hif.lfsr_reset) begin
        pulses++;
        if (pulses > 1) chk("line_period", gap, 57);
        gap = 0;
        cur = 6'h00;
      end else begin
        cur = lnext(cur);
      end
    end
    chk("free_run_pulses", pulses, 4);

    for (int i = 0; i < 6; i++) step(seq[i], 0);
    hif.lfsr_in = seq[6];
    @(posedge s1);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_hsync", hif.hsync, 0);
    chk("mid_rst_hblank", hif.hblank, 1);
    chk("mid_rst_lfsr_reset", hif.lfsr_reset, 0);
    chk("mid_rst_cb", hif.cb, 0);
    sb.delete();
    model_reset();
    @(posedge s2);
    #1;
    chk("hold_rst_lfsr_reset", hif.lfsr_reset, 0);
    chk("hold_rst_hblank", hif.hblank, 1);
    @(negedge s2);
    reset = 0;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        rv = seq[$urandom_range(0, 56)];
      else
        rv = 6'($urandom_range(0, 63));
      step(rv, $urandom_range(0, 15) == 0);
    end

    line(-1);
    line(5);

    @(negedge s2);
    @(negedge s2);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
